l2_arbiter: RTL

- Two-port arbiter sharing the single L2 cache port between the L1 instruction cache (I-port) and the L1 data cache (D-port).
- Sits between the L1 caches and the L2 controller/data array.
- Serialises line-sized read/write transactions, one outstanding at a time.
- Round-robin fairness by default.
- All L2-facing and L1-facing outputs are registered.

---
 rtl/l2_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/l2_arbiter.sv
// Two-port L2 arbiter: serialises I-cache and D-cache line transactions onto one L2 port.
// Define L2_ARB_DPORT_PRIO_EN for fixed D-port priority; default build is round-robin.
module l2_arbiter #(
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [S_LINE-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [S_LINE-1:0] d_wdata,
    output logic [S_LINE-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [S_LINE-1:0] l2_wdata,
    input  logic [S_LINE-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << S_OFFSET) - ADDR_W'(1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              grant_d, grant_d_next;
    logic              l2_read_next, l2_write_next;
    logic              i_resp_next, d_resp_next;
    logic [ADDR_W-1:0] l2_address_next;
    logic [S_LINE-1:0] l2_wdata_next, i_rdata_next, d_rdata_next;
    logic              i_req, d_req, pick_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef L2_ARB_DPORT_PRIO_EN
    assign pick_d = d_req;
`else
    // rr_d high means the D-port wins the next contested IDLE cycle
    logic rr_d, rr_d_next;
    assign pick_d = d_req & (~i_req | rr_d);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_d    <= 1'b0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_address <= '0;
            l2_wdata   <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
`ifndef L2_ARB_DPORT_PRIO_EN
            rr_d       <= 1'b1;
`endif
        end else begin
            state      <= state_next;
            grant_d    <= grant_d_next;
            l2_read    <= l2_read_next;
            l2_write   <= l2_write_next;
            l2_address <= l2_address_next;
            l2_wdata   <= l2_wdata_next;
            i_rdata    <= i_rdata_next;
            d_rdata    <= d_rdata_next;
            i_resp     <= i_resp_next;
            d_resp     <= d_resp_next;
`ifndef L2_ARB_DPORT_PRIO_EN
            rr_d       <= rr_d_next;
`endif
        end
    end

    always_comb begin
        state_next      = state;
        grant_d_next    = grant_d;
        l2_read_next    = l2_read;
        l2_write_next   = l2_write;
        l2_address_next = l2_address;
        l2_wdata_next   = l2_wdata;
        i_rdata_next    = i_rdata;
        d_rdata_next    = d_rdata;
        i_resp_next     = 1'b0;
        d_resp_next     = 1'b0;
`ifndef L2_ARB_DPORT_PRIO_EN
        rr_d_next       = rr_d;
`endif
        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    state_next      = BUSY;
                    grant_d_next    = pick_d;
                    // d_read together with d_write is treated as a write
                    l2_write_next   = pick_d & d_write;
                    l2_read_next    = ~(pick_d & d_write);
                    l2_address_next = (pick_d ? d_address : i_address) & LINE_MASK;
                    l2_wdata_next   = d_wdata;
`ifndef L2_ARB_DPORT_PRIO_EN
                    rr_d_next       = ~pick_d;
`endif
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    state_next    = RESP;
                    l2_read_next  = 1'b0;
                    l2_write_next = 1'b0;
                    if (grant_d) begin
                        d_rdata_next = l2_rdata;
                        d_resp_next  = 1'b1;
                    end else begin
                        i_rdata_next = l2_rdata;
                        i_resp_next  = 1'b1;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
